// File: rtl/uart_rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_assembler
// Purpose  : 8N1 UART receiver (LSB first, runtime bit period) that packs
//            received bytes little-endian into BYTES_PER_WORD-byte words and
//            hands each word to a consumer over a valid/ack handshake.
//            Flags framing errors (one-cycle pulse) and word overflow (sticky).
// Ports    : clk          - system clock
//            rst_l        - asynchronous active-low reset
//            r_Rx_Serial  - asynchronous serial line, idles high
//            CLKS_PER_BIT - clk cycles per bit, latched at start-bit detect
//            o_Rx_DV      - one-cycle strobe, o_Rx_Byte holds a new byte
//            o_Rx_Byte    - last good received byte
//            o_word_valid - o_word holds a complete word until acked
//            o_word       - assembled word, first byte in [7:0]
//            i_word_ack   - consumer accepts o_word
//            o_frame_err  - one-cycle pulse on a bad stop bit
//            o_overflow   - sticky, word completed while previous unacked
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_assembler #(
  parameter int BYTES_PER_WORD = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        r_Rx_Serial,
  input  logic [15:0] CLKS_PER_BIT,
  output logic        o_Rx_DV,
  output logic [7:0]  o_Rx_Byte,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  input  logic        i_word_ack,
  output logic        o_frame_err,
  output logic        o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // --------------------------------------------------------------------------
  // Input synchroniser; resets to the idle (high) line level
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], r_Rx_Serial};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [15:0] cpb_q, cpb_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_dv_q, rx_dv_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        frame_err_q, frame_err_d;

  logic [15:0] cpb_in;
  logic        half_hit;
  logic        full_hit;

  assign cpb_in   = (CLKS_PER_BIT < 16'd2) ? 16'd2 : CLKS_PER_BIT;
  assign half_hit = (clk_cnt_q == ((cpb_q >> 1) - 16'd1));
  assign full_hit = (clk_cnt_q == (cpb_q - 16'd1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      cpb_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      cpb_q       <= cpb_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + 16'd1;
    cpb_d       = cpb_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          cpb_d   = cpb_in;
        end
      end

      // Mid-start-bit sample rejects short low glitches
      S_START: begin
        if (half_hit) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end
      end

      // Counter restarts per bit so every sample stays at mid-bit
      S_DATA: begin
        if (full_hit) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d   = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end

      S_STOP: begin
        if (full_hit) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rx_dv_d   = 1'b1;
            rx_byte_d = shift_q;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end

      // A held-low break must not restart reception until the line recovers
      S_WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Word assembly and consumer handshake
  // --------------------------------------------------------------------------
  logic [31:0] word_buf_q, word_buf_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        overflow_q, overflow_d;
  logic [31:0] word_merged;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      word_buf_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      word_buf_q   <= word_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Byte lanes above BYTES_PER_WORD are never written, so they stay zero
  always_comb begin
    word_merged                           = word_buf_q;
    word_merged[{byte_cnt_q, 3'b000} +: 8] = rx_byte_q;
  end

  always_comb begin
    word_buf_d   = word_buf_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;

    if (word_valid_q && i_word_ack) word_valid_d = 1'b0;

    // A framing error resynchronises word alignment to the next good byte
    if (frame_err_q) begin
      byte_cnt_d = '0;
    end else if (rx_dv_q) begin
      word_buf_d = word_merged;
      if (byte_cnt_q == LAST_BYTE) begin
        byte_cnt_d   = '0;
        word_d       = word_merged;
        word_valid_d = 1'b1;
        // Completion together with ack is a clean hand-over, not an overflow
        if (word_valid_q && !i_word_ack) overflow_d = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

  assign o_Rx_DV      = rx_dv_q;
  assign o_Rx_Byte    = rx_byte_q;
  assign o_frame_err  = frame_err_q;
  assign o_word_valid = word_valid_q;
  assign o_word       = word_q;
  assign o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_word_assembler
// Purpose  : Self-checking bench for uart_rx_word_assembler. Serial frames are
//            generated at a chosen bit period; expected bytes and words come
//            from the transmitted data (little-endian packing of good bytes).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_assembler;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        r_Rx_Serial;
  logic [15:0] CLKS_PER_BIT;
  logic        i_word_ack;
  logic        o_Rx_DV;
  logic [7:0]  o_Rx_Byte;
  logic        o_word_valid;
  logic [31:0] o_word;
  logic        o_frame_err;
  logic        o_overflow;

  int n_checks = 0;
  int n_fails  = 0;

  // Monitor-owned event counters
  int         dv_cnt    = 0;
  int         ferr_cnt  = 0;
  logic [7:0] last_byte = 8'h00;

  // Observations captured while driving a stop bit
  logic valid_at_dv;
  logic valid_after_dv;
  bit   acked_on_dv;

  always #5 clk = ~clk;

  uart_rx_word_assembler #(
    .BYTES_PER_WORD(4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .r_Rx_Serial (r_Rx_Serial),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .o_Rx_DV     (o_Rx_DV),
    .o_Rx_Byte   (o_Rx_Byte),
    .o_word_valid(o_word_valid),
    .o_word      (o_word),
    .i_word_ack  (i_word_ack),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow)
  );

  always @(negedge clk) begin
    if (rst_l) begin
      if (o_Rx_DV) begin
        dv_cnt    = dv_cnt + 1;
        last_byte = o_Rx_Byte;
      end
      if (o_frame_err) ferr_cnt = ferr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l       = 1'b0;
    r_Rx_Serial = 1'b1;
    i_word_ack  = 1'b0;
    tick(3);
    rst_l = 1'b1;
    tick(2);
  endtask

  // One 8N1 frame. ack_on_dv raises i_word_ack for exactly the cycle in which
  // o_Rx_DV is seen; chg_bit switches CLKS_PER_BIT to 16 at that data bit.
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop,
                           input bit ack_on_dv = 1'b0, input int chg_bit = -1);
    int dv_at;
    r_Rx_Serial = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) CLKS_PER_BIT = 16'd16;
      r_Rx_Serial = b[i];
      tick(cpb);
    end
    r_Rx_Serial    = stop;
    valid_at_dv    = 1'b0;
    valid_after_dv = 1'b0;
    acked_on_dv    = 1'b0;
    dv_at          = -1;
    for (int i = 0; i < cpb; i++) begin
      if (dv_at >= 0 && dv_at == i - 1) valid_after_dv = o_word_valid;
      if (o_Rx_DV && dv_at < 0) begin
        dv_at       = i;
        valid_at_dv = o_word_valid;
        if (ack_on_dv) begin
          i_word_ack  = 1'b1;
          acked_on_dv = 1'b1;
        end
      end else if (ack_on_dv) begin
        i_word_ack = 1'b0;
      end
      tick(1);
    end
    if (ack_on_dv) i_word_ack = 1'b0;
  endtask

  // Sends n bytes first, first+step, ... at 16 clocks per bit
  task automatic send_run(input logic [7:0] first, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      send_byte(b, 16, 1'b1);
      b = b + step;
    end
  endtask

  initial begin
    int         base;
    int         fbase;
    bit         stable;
    logic [31:0] held;
    logic [7:0] rb;
    int         rcpb;
    int         mdl_cnt;
    logic [31:0] mdl_word;

    rst_l        = 1'b0;
    r_Rx_Serial  = 1'b1;
    CLKS_PER_BIT = 16'd16;
    i_word_ack   = 1'b0;
    tick(2);

    // Reset state
    check("rst_dv",       {31'd0, o_Rx_DV},      32'd0);
    check("rst_byte",     {24'd0, o_Rx_Byte},    32'd0);
    check("rst_valid",    {31'd0, o_word_valid}, 32'd0);
    check("rst_word",     o_word,                32'd0);
    check("rst_ferr",     {31'd0, o_frame_err},  32'd0);
    check("rst_overflow", {31'd0, o_overflow},   32'd0);
    rst_l = 1'b1;
    tick(2);

    // Single byte
    base  = dv_cnt;
    fbase = ferr_cnt;
    send_byte(8'hA5, 16, 1'b1);
    tick(16);
    check("one_dv_count", dv_cnt - base,          1);
    check("one_byte",     {24'd0, last_byte},     32'hA5);
    check("one_ferr",     ferr_cnt - fbase,       0);
    check("one_valid",    {31'd0, o_word_valid},  32'd0);

    // Four bytes make a word; hold it, then ack
    do_reset();
    send_run(8'h11, 8'h11, 4);
    check("word_lat_dv",   {31'd0, valid_at_dv},    32'd0);
    check("word_lat_next", {31'd0, valid_after_dv}, 32'd1);
    check("word_valid",    {31'd0, o_word_valid},   32'd1);
    check("word_value",    o_word,                  32'h44332211);
    held   = o_word;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (o_word !== held || o_word_valid !== 1'b1) stable = 1'b0;
    end
    check("word_stable", {31'd0, stable}, 32'd1);
    i_word_ack = 1'b1;
    tick(1);
    i_word_ack = 1'b0;
    check("word_ack_drop", {31'd0, o_word_valid}, 32'd0);
    tick(5);
    check("word_ack_stays", {31'd0, o_word_valid}, 32'd0);

    // Short low glitch must be rejected
    base  = dv_cnt;
    fbase = ferr_cnt;
    r_Rx_Serial = 1'b0;
    tick(3);
    r_Rx_Serial = 1'b1;
    tick(40);
    check("glitch_dv",   dv_cnt - base,    0);
    check("glitch_ferr", ferr_cnt - fbase, 0);
    send_byte(8'h3C, 16, 1'b1);
    tick(16);
    check("glitch_after_byte", {24'd0, last_byte}, 32'h3C);

    // Framing error followed by a long break, then word resync
    do_reset();
    send_byte(8'h99, 16, 1'b1);
    base  = dv_cnt;
    fbase = ferr_cnt;
    send_byte(8'h55, 16, 1'b0);
    r_Rx_Serial = 1'b0;
    tick(200);
    r_Rx_Serial = 1'b1;
    tick(32);
    check("ferr_count", ferr_cnt - fbase, 1);
    check("ferr_no_dv", dv_cnt - base,    0);
    send_run(8'h01, 8'h01, 4);
    check("resync_valid", {31'd0, o_word_valid}, 32'd1);
    check("resync_word",  o_word,                32'h04030201);

    // Overflow: two words without ack
    do_reset();
    send_run(8'h01, 8'h01, 8);
    check("ovf_flag",  {31'd0, o_overflow},   32'd1);
    check("ovf_word",  o_word,                32'h08070605);
    check("ovf_valid", {31'd0, o_word_valid}, 32'd1);
    tick(20);
    check("ovf_sticky", {31'd0, o_overflow}, 32'd1);

    // Ack coincident with completion of the second word
    do_reset();
    send_run(8'h01, 8'h01, 7);
    send_byte(8'h08, 16, 1'b1, 1'b1);
    check("sim_acked", {31'd0, acked_on_dv},  32'd1);
    check("sim_valid", {31'd0, o_word_valid}, 32'd1);
    check("sim_word",  o_word,                32'h08070605);
    check("sim_ovf",   {31'd0, o_overflow},   32'd0);

    // Long bit period, CLKS_PER_BIT changed mid-frame
    do_reset();
    CLKS_PER_BIT = 16'd348;
    base = dv_cnt;
    send_byte(8'hC3, 348, 1'b1, 1'b0, 3);
    tick(16);
    check("slow_dv",   dv_cnt - base,      1);
    check("slow_byte", {24'd0, last_byte}, 32'hC3);
    send_run(8'h10, 8'h10, 3);
    check("slow_word", o_word, 32'h302010C3);

    // Reset mid-byte clears everything at once
    r_Rx_Serial = 1'b0;
    tick(16);
    r_Rx_Serial = 1'b1;
    tick(16);
    r_Rx_Serial = 1'b0;
    tick(16);
    rst_l = 1'b0;
    #1;
    check("midrst_byte",  {24'd0, o_Rx_Byte},    32'd0);
    check("midrst_valid", {31'd0, o_word_valid}, 32'd0);
    check("midrst_word",  o_word,                32'd0);
    check("midrst_dv",    {31'd0, o_Rx_DV},      32'd0);
    r_Rx_Serial = 1'b1;
    tick(3);
    rst_l = 1'b1;
    tick(2);
    base = dv_cnt;
    send_byte(8'h5A, 16, 1'b1);
    tick(16);
    check("postrst_dv",   dv_cnt - base,      1);
    check("postrst_byte", {24'd0, last_byte}, 32'h5A);

    // Bit period below the floor is treated as 2
    do_reset();
    CLKS_PER_BIT = 16'd0;
    base = dv_cnt;
    send_byte(8'h96, 2, 1'b1);
    tick(8);
    check("min_cpb_dv",   dv_cnt - base,      1);
    check("min_cpb_byte", {24'd0, last_byte}, 32'h96);

    // Random bytes at random bit periods against a packing model
    do_reset();
    mdl_cnt  = 0;
    mdl_word = 32'd0;
    for (int k = 0; k < 12; k++) begin
      rb           = 8'($urandom);
      rcpb         = int'($urandom_range(4, 40));
      CLKS_PER_BIT = 16'(rcpb);
      send_byte(rb, rcpb, 1'b1);
      tick(2);
      check("rnd_byte", {24'd0, last_byte}, {24'd0, rb});
      mdl_word = mdl_word | ({24'd0, rb} << (8 * mdl_cnt));
      mdl_cnt++;
      if (mdl_cnt == 4) begin
        check("rnd_valid", {31'd0, o_word_valid}, 32'd1);
        check("rnd_word",  o_word,                mdl_word);
        i_word_ack = 1'b1;
        tick(1);
        i_word_ack = 1'b0;
        mdl_cnt  = 0;
        mdl_word = 32'd0;
      end else begin
        check("rnd_not_valid", {31'd0, o_word_valid}, 32'd0);
      end
    end
    check("rnd_no_ovf",  {31'd0, o_overflow}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
